store_unit: RTL

- Memory-write side of the datapath: the write counterpart to the operand path that pulls memory words into the ALU.
- Takes a store request (SW/SH/SB), the register value (read_data2) and a byte address, and produces a full-word write to the word-addressed data memory.
- SW issues a direct write; SH/SB perform read-modify-write so untouched byte lanes are preserved.
- Sits between the control FSM and the data memory port; holds the memory port while busy.

---
 rtl/store_unit_pkg.sv | 37 +++
 rtl/store_merge.sv | 32 +++
 rtl/store_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/store_unit_pkg.sv
// Shared types and constants for the store unit: size codes, FSM states, byte-lane selects.
package store_unit_pkg;

  typedef enum logic [1:0] {
    SizeSw  = 2'b00,
    SizeSh  = 2'b01,
    SizeSb  = 2'b10,
    SizeBad = 2'b11
  } store_size_e;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StMerge,
    StWrite,
    StErr
  } state_e;

  // Little-endian byte lanes within a 32-bit word.
  localparam logic [1:0] Lane0 = 2'd0;
  localparam logic [1:0] Lane1 = 2'd1;
  localparam logic [1:0] Lane2 = 2'd2;
  localparam logic [1:0] Lane3 = 2'd3;

  // True when the request cannot be performed: illegal size or misaligned address.
  function automatic logic req_bad(store_size_e size, logic [1:0] lo);
    logic bad;
    case (size)
      SizeSw:  bad = (lo != 2'b00);
      SizeSh:  bad = lo[0];
      SizeSb:  bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge: replaces the addressed byte/halfword of a held word with store data.
module store_merge
  import store_unit_pkg::*;
(
  input  logic [31:0] held_i,
  input  logic [31:0] data_i,
  input  store_size_e size_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = held_i;
    case (size_i)
      SizeSw: merged_o = data_i;
      SizeSh: begin
        if (lane_i[1]) merged_o[31:16] = data_i[15:0];
        else           merged_o[15:0]  = data_i[15:0];
      end
      SizeSb: begin
        unique case (lane_i)
          Lane0: merged_o[7:0]   = data_i[7:0];
          Lane1: merged_o[15:8]  = data_i[7:0];
          Lane2: merged_o[23:16] = data_i[7:0];
          Lane3: merged_o[31:24] = data_i[7:0];
        endcase
      end
      default: merged_o = held_i;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: SW writes directly, SH/SB read-modify-write the addressed word.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int unsigned MemLat = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  store_size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] read_data2_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_wr_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam logic [2:0] LastCnt = 3'(MemLat - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  store_size_e size_q;
  logic [31:0] addr_q;
  logic [1:0]  lane_q;
  logic [31:0] data_q;
  logic [31:0] hold_q;
  logic        accept;
  logic        rd_last;

  assign accept  = (state_q == StIdle) && start_i;
  assign rd_last = (state_q == StRd) && (cnt_q == LastCnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      size_q  <= SizeSw;
      addr_q  <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        size_q <= store_size_e'(store_size_i);
        addr_q <= {addr_i[31:2], 2'b00};
        lane_q <= addr_i[1:0];
        data_q <= read_data2_i;
      end
      if (rd_last) hold_q <= mem_rdata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start_i) begin
          if (req_bad(store_size_e'(store_size_i), addr_i[1:0])) state_d = StErr;
          else if (store_size_e'(store_size_i) == SizeSw)        state_d = StWrite;
          else                                                   state_d = StRd;
        end
      end
      StRd: begin
        if (rd_last) state_d = StMerge;
        else         cnt_d   = cnt_q + 3'd1;
      end
      StMerge: state_d = StWrite;
      StWrite: state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  store_merge u_merge (
    .held_i   (hold_q),
    .data_i   (data_q),
    .size_i   (size_q),
    .lane_i   (lane_q),
    .merged_o (mem_wdata_o)
  );

  assign mem_addr_o = addr_q;
  assign mem_wr_o   = (state_q == StWrite);
  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StWrite) || (state_q == StErr);
  assign error_o    = (state_q == StErr);

endmodule
